led_stretch_all: RTL and testbench

- Output-side counterpart to the board's switch/key debounce: drives LEDR[9:0] from short internal event pulses.
- A debouncer removes short glitches from slow human inputs. This block stretches short (single-cycle) events into fixed-length, human-visible LED pulses.
- A global PWM duty input sets LED brightness.
- Sits between user logic and the LED pins; one independent channel per LED.

---
 rtl/led_stretch_all_if.sv | 13 +
 rtl/led_stretch_all.sv | 86 ++++++++
 tb/tb_led_stretch_all.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/led_stretch_all_if.sv
// Bundles the per-channel event requests, global brightness and LED/busy outputs of led_stretch_all.
interface led_stretch_all_if #(
  parameter int NUM_LED = 10,
  parameter int PWM_W   = 4
);
  logic [NUM_LED-1:0] iEvent;
  logic [PWM_W-1:0]   iDuty;
  logic [NUM_LED-1:0] oLED;
  logic               oBusy;

  modport master (output iEvent, output iDuty, input oLED, input oBusy);
  modport slave  (input iEvent, input iDuty, output oLED, output oBusy);
endinterface

// File: rtl/led_stretch_all.sv
// Stretches single-cycle events into fixed-length LED pulses, one retriggerable channel per LED,
// with a shared PWM brightness gate.
module led_stretch_all #(
  parameter int NUM_LED     = 10,
  parameter int HOLD_CYCLES = 2500000,
  parameter int CNT_W       = 22,
  parameter int PWM_W       = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  led_stretch_all_if.slave bus
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(HOLD_CYCLES - 1);

  state_t             r_state [NUM_LED];
  logic [CNT_W-1:0]   r_cnt   [NUM_LED];
  logic [NUM_LED-1:0] r_evQ;
  logic [NUM_LED-1:0] r_led;
  logic               r_busy;
  logic [PWM_W-1:0]   r_pwmCnt;

  logic [NUM_LED-1:0] w_rise;
  logic [NUM_LED-1:0] w_hold;
  logic               w_pwmOn;

  assign w_rise = bus.iEvent & ~r_evQ;

  // All-ones duty must be fully on, so it bypasses the compare that would drop pwm_cnt == all-ones.
  assign w_pwmOn = (&bus.iDuty) | (r_pwmCnt < bus.iDuty);

  always_comb begin
    w_hold = '0;
    for (int i = 0; i < NUM_LED; i++) begin
      w_hold[i] = (r_state[i] == HOLD);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_evQ    <= '0;
      r_pwmCnt <= '0;
      r_led    <= '0;
      r_busy   <= 1'b0;
      for (int i = 0; i < NUM_LED; i++) begin
        r_state[i] <= IDLE;
        r_cnt[i]   <= '0;
      end
    end else begin
      r_evQ    <= bus.iEvent;
      r_pwmCnt <= r_pwmCnt + 1'b1;
      // Outputs follow the state register one cycle later, so a pulse lasts exactly HOLD_CYCLES.
      r_led    <= w_hold & {NUM_LED{w_pwmOn}};
      r_busy   <= |w_hold;
      for (int i = 0; i < NUM_LED; i++) begin
        case (r_state[i])
          IDLE: begin
            if (w_rise[i]) begin
              r_state[i] <= HOLD;
              r_cnt[i]   <= LOAD_CNT;
            end
          end
          HOLD: begin
            if (w_rise[i]) begin
              r_cnt[i] <= LOAD_CNT;
            end else if (r_cnt[i] == '0) begin
              r_state[i] <= IDLE;
            end else begin
              r_cnt[i] <= r_cnt[i] - 1'b1;
            end
          end
          default: begin
            r_state[i] <= IDLE;
            r_cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.oLED  = r_led;
  assign bus.oBusy = r_busy;

endmodule

// File: tb/tb_led_stretch_all.sv
// Scoreboard bench for led_stretch_all: a per-edge reference model queues expected outputs,
// a monitor pops and compares them one step after every clock edge.
module tb_led_stretch_all;

  localparam int NUM_LED     = 10;
  localparam int HOLD_CYCLES = 8;
  localparam int CNT_W       = 4;
  localparam int PWM_W       = 4;

  logic clk;
  logic rst_n;
  int   numChecks;
  int   numFails;
  logic monitorOn;

  logic [NUM_LED:0] expQ[$];

  led_stretch_all_if #(.NUM_LED(NUM_LED), .PWM_W(PWM_W)) bus ();

  led_stretch_all #(
    .NUM_LED(NUM_LED), .HOLD_CYCLES(HOLD_CYCLES), .CNT_W(CNT_W), .PWM_W(PWM_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: a channel is lit while its most recent rise lies fewer than HOLD_CYCLES edges back,
  // shown one cycle late and gated by where the PWM period stands.
  int               edgeNum;
  int               lastRise [NUM_LED];
  logic [NUM_LED-1:0] prevEv;
  int               pwmPos;

  initial begin
    edgeNum = 0;
    pwmPos  = 0;
    prevEv  = '0;
    for (int i = 0; i < NUM_LED; i++) lastRise[i] = -100000;
  end

  always @(posedge clk) begin
    logic [NUM_LED-1:0] expLed;
    logic               expBusy;
    logic               pwmOn;
    logic               wasActive;
    expLed  = '0;
    expBusy = 1'b0;
    if (!rst_n) begin
      prevEv = '0;
      pwmPos = 0;
      for (int i = 0; i < NUM_LED; i++) lastRise[i] = -100000;
    end else begin
      pwmOn = (int'(bus.iDuty) == (1 << PWM_W) - 1) || (pwmPos < int'(bus.iDuty));
      for (int i = 0; i < NUM_LED; i++) begin
        wasActive = ((edgeNum - 1 - lastRise[i]) < HOLD_CYCLES);
        expLed[i] = wasActive && pwmOn;
        if (wasActive) expBusy = 1'b1;
        if (bus.iEvent[i] && !prevEv[i]) lastRise[i] = edgeNum;
      end
      prevEv = bus.iEvent;
      pwmPos = (pwmPos + 1) % (1 << PWM_W);
    end
    expQ.push_back({expBusy, expLed});
    edgeNum++;
  end

  task automatic checkOutput(input string name, input logic [NUM_LED-1:0] actual,
                             input logic [NUM_LED-1:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFails++;
      $display("[TB] FAIL %s at t=%0t: got %b, expected %b", name, $time, actual, expected);
    end
  endtask

  always @(posedge clk) begin
    logic [NUM_LED:0] exp;
    #1;
    if (monitorOn) begin
      if (expQ.size() == 0) begin
        numChecks++;
        numFails++;
        $display("[TB] FAIL scoreboard at t=%0t: got empty queue, expected an entry", $time);
      end else begin
        exp = expQ.pop_front();
        checkOutput("oLED", bus.oLED, exp[NUM_LED-1:0]);
        checkOutput("oBusy", {{(NUM_LED-1){1'b0}}, bus.oBusy}, {{(NUM_LED-1){1'b0}}, exp[NUM_LED]});
      end
    end
  end

  task automatic applyStimulus(input logic rstN, input logic [NUM_LED-1:0] ev,
                               input logic [PWM_W-1:0] duty, input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      rst_n      = rstN;
      bus.iEvent = ev;
      bus.iDuty  = duty;
    end
  endtask

  initial begin
    numChecks  = 0;
    numFails   = 0;
    monitorOn  = 1'b1;
    rst_n      = 1'b0;
    bus.iEvent = '0;
    bus.iDuty  = 4'hF;

    applyStimulus(1'b0, 10'h000, 4'hF, 3);
    applyStimulus(1'b1, 10'h000, 4'hF, 3);

    $display("[TB] single pulse on channel 0");
    applyStimulus(1'b1, 10'h001, 4'hF, 1);
    applyStimulus(1'b1, 10'h000, 4'hF, 12);

    $display("[TB] held level, retrigger and cnt==0 retrigger on channel 3");
    applyStimulus(1'b1, 10'h008, 4'hF, 20);
    applyStimulus(1'b1, 10'h000, 4'hF, 3);
    applyStimulus(1'b1, 10'h008, 4'hF, 1);
    applyStimulus(1'b1, 10'h000, 4'hF, 4);
    applyStimulus(1'b1, 10'h008, 4'hF, 1);
    applyStimulus(1'b1, 10'h000, 4'hF, 15);
    applyStimulus(1'b1, 10'h008, 4'hF, 1);
    applyStimulus(1'b1, 10'h000, 4'hF, 7);
    applyStimulus(1'b1, 10'h008, 4'hF, 1);
    applyStimulus(1'b1, 10'h000, 4'hF, 12);

    $display("[TB] brightness duty 4 then duty 0 on channel 2");
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 10'h004, 4'h4, 1);
      applyStimulus(1'b1, 10'h000, 4'h4, 5);
    end
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 10'h004, 4'h0, 1);
      applyStimulus(1'b1, 10'h000, 4'h0, 5);
    end
    applyStimulus(1'b1, 10'h000, 4'hF, 10);

    $display("[TB] parallel channels 0, 9 and 5");
    applyStimulus(1'b1, 10'h201, 4'hF, 1);
    applyStimulus(1'b1, 10'h000, 4'hF, 1);
    applyStimulus(1'b1, 10'h020, 4'hF, 1);
    applyStimulus(1'b1, 10'h000, 4'hF, 12);

    $display("[TB] reset mid-hold with event held through release");
    applyStimulus(1'b1, 10'h002, 4'hF, 1);
    applyStimulus(1'b1, 10'h000, 4'hF, 2);
    applyStimulus(1'b0, 10'h002, 4'hF, 2);
    applyStimulus(1'b1, 10'h002, 4'hF, 12);
    applyStimulus(1'b1, 10'h000, 4'hF, 4);

    $display("[TB] randomized traffic");
    for (int k = 0; k < 300; k++) begin
      logic [NUM_LED-1:0] ev;
      logic [PWM_W-1:0]   duty;
      logic               rstN;
      ev   = NUM_LED'($urandom & $urandom & $urandom);
      duty = (k < 150) ? 4'hF : PWM_W'($urandom_range(0, 15));
      rstN = ($urandom_range(0, 63) != 0);
      applyStimulus(rstN, ev, duty, 1);
    end
    applyStimulus(1'b1, 10'h000, 4'hF, 12);

    @(posedge clk);
    #2;
    monitorOn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
